// File: rtl/cpu_interrupt_sequencer.sv
// cpu_interrupt_sequencer
//
// Bus front-end that sits between the CPU core and the memory bus. It runs
// three sequences on the divided bus clock:
//   - reset vector fetch (out of reset),
//   - NMI entry and IRQ entry: push PCH, PCL and P to the stack page, then
//     fetch the 16-bit vector.
// While busy_o=1 the sequencer owns the bus. On completion it pulses done_o
// and presents the new PC/SP/P to the core.
//
// Build option:
//   CPU_INTERRUPT_SEQUENCER_NMI_HIJACK_EN - when defined, an NMI edge seen
//   during the push phase of an IRQ entry redirects that entry to the NMI
//   vector and consumes the NMI. When undefined, the IRQ finishes with its
//   own vector and the NMI stays pending for the next boundary.
//
// Ports:
//   clock_i          system clock
//   reset_i          synchronous reset, active-high
//   data_i           read data
//   data_valid_i     read data valid (sampled on bus ticks only)
//   nmi_i            NMI request, rising-edge sensitive
//   irq_i            IRQ request, level sensitive
//   boundary_i       core at instruction boundary (1-cycle pulse)
//   pc_i/sp_i/status_i  core PC/SP/P, sampled when a sequence starts
//   data_o           write data
//   address_o        bus address
//   address_valid_o  bus cycle active
//   data_valid_o     1 = write cycle, 0 = read cycle
//   busy_o           sequencer owns the bus
//   done_o           1-cycle pulse, pc_o/sp_o/status_o valid
//   pc_o/sp_o/status_o  new PC/SP/P
//   clock_ready_o    bus tick strobe
//
// state   | meaning
// --------+---------------------------------------------------------
// RST_LO  | read RESET_VECTOR (vector low byte)
// RST_HI  | read RESET_VECTOR+1, publish PC, pulse done
// IDLE    | bus released, wait for boundary with NMI/IRQ pending
// PUSH_H  | write PC[15:8] to stack, SP-1
// PUSH_L  | write PC[7:0] to stack, SP-1
// PUSH_P  | write P (B=0, bit5=1) to stack, SP-1
// VEC_LO  | read selected vector low byte
// VEC_HI  | read vector+1, publish PC/SP/P, pulse done

module cpu_interrupt_sequencer #(
    parameter int unsigned CLOCK_DIVIDER = 12,
    parameter logic [15:0] RESET_VECTOR  = 16'hFFFC,
    parameter logic [15:0] NMI_VECTOR    = 16'hFFFA,
    parameter logic [15:0] IRQ_VECTOR    = 16'hFFFE,
    parameter logic [7:0]  STACK_PAGE    = 8'h01
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    input  logic        nmi_i,
    input  logic        irq_i,
    input  logic        boundary_i,
    input  logic [15:0] pc_i,
    input  logic [7:0]  sp_i,
    input  logic [7:0]  status_i,
    output logic [7:0]  data_o,
    output logic [15:0] address_o,
    output logic        address_valid_o,
    output logic        data_valid_o,
    output logic        busy_o,
    output logic        done_o,
    output logic [15:0] pc_o,
    output logic [7:0]  sp_o,
    output logic [7:0]  status_o,
    output logic        clock_ready_o
);

    localparam int unsigned       CNT_W    = $clog2(CLOCK_DIVIDER) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLOCK_DIVIDER - 1);

    typedef enum logic [2:0] {
        S_RST_LO,
        S_RST_HI,
        S_IDLE,
        S_PUSH_H,
        S_PUSH_L,
        S_PUSH_P,
        S_VEC_LO,
        S_VEC_HI
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic [7:0]        pc_lo_q, pc_lo_d;
    logic [15:0]       pc_q, pc_d;
    logic [7:0]        sp_q, sp_d;
    logic [7:0]        stat_q, stat_d;
    logic [15:0]       vec_q, vec_d;
    logic              nmi_prev_q, nmi_prev_d;
    logic              nmi_pend_q, nmi_pend_d;
    logic              done_q, done_d;
    logic [15:0]       pc_out_q, pc_out_d;
    logic [7:0]        sp_out_q, sp_out_d;
    logic [7:0]        status_out_q, status_out_d;

    logic              nmi_edge;
    logic              rd_ok;
    logic              push_state;

    // Bus tick divider: tick goes high for one clock after CLOCK_DIVIDER clocks.
    always_comb begin
        cnt_d  = cnt_q + CNT_W'(1);
        tick_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end
    end

    assign nmi_edge   = nmi_i & ~nmi_prev_q;
    assign rd_ok      = tick_q & data_valid_i;
    assign push_state = (state_q == S_PUSH_H) || (state_q == S_PUSH_L) ||
                        (state_q == S_PUSH_P);

    always_comb begin
        state_d      = state_q;
        pc_lo_d      = pc_lo_q;
        pc_d         = pc_q;
        sp_d         = sp_q;
        stat_d       = stat_q;
        vec_d        = vec_q;
        nmi_prev_d   = nmi_i;
        nmi_pend_d   = nmi_pend_q | nmi_edge;
        done_d       = 1'b0;
        pc_out_d     = pc_out_q;
        sp_out_d     = sp_out_q;
        status_out_d = status_out_q;

        case (state_q)
            S_RST_LO: begin
                if (rd_ok) begin
                    pc_lo_d = data_i;
                    state_d = S_RST_HI;
                end
            end
            S_RST_HI: begin
                if (rd_ok) begin
                    pc_out_d = {data_i, pc_lo_q};
                    done_d   = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_IDLE: begin
                // Start is taken on the boundary cycle itself, not on a tick.
                if (boundary_i) begin
                    if (nmi_pend_q) begin
                        pc_d       = pc_i;
                        sp_d       = sp_i;
                        stat_d     = status_i;
                        vec_d      = NMI_VECTOR;
                        // An edge arriving on this very cycle re-arms pending.
                        nmi_pend_d = nmi_edge;
                        state_d    = S_PUSH_H;
                    end else if (irq_i && !status_i[2]) begin
                        pc_d    = pc_i;
                        sp_d    = sp_i;
                        stat_d  = status_i;
                        vec_d   = IRQ_VECTOR;
                        state_d = S_PUSH_H;
                    end
                end
            end
            S_PUSH_H: begin
                if (tick_q) begin
                    sp_d    = sp_q - 8'd1;
                    state_d = S_PUSH_L;
                end
            end
            S_PUSH_L: begin
                if (tick_q) begin
                    sp_d    = sp_q - 8'd1;
                    state_d = S_PUSH_P;
                end
            end
            S_PUSH_P: begin
                if (tick_q) begin
                    sp_d    = sp_q - 8'd1;
                    state_d = S_VEC_LO;
                end
            end
            S_VEC_LO: begin
                if (rd_ok) begin
                    pc_lo_d = data_i;
                    state_d = S_VEC_HI;
                end
            end
            S_VEC_HI: begin
                if (rd_ok) begin
                    pc_out_d     = {data_i, pc_lo_q};
                    sp_out_d     = sp_q;
                    status_out_d = stat_q | 8'h04;
                    done_d       = 1'b1;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_RST_LO;
        endcase

`ifdef CPU_INTERRUPT_SEQUENCER_NMI_HIJACK_EN
        // Once redirected, vec_q holds NMI_VECTOR, so a further edge in the
        // same push phase is left pending rather than absorbed twice.
        if (push_state && nmi_edge && (vec_q == IRQ_VECTOR) &&
            (NMI_VECTOR != IRQ_VECTOR)) begin
            vec_d      = NMI_VECTOR;
            nmi_pend_d = 1'b0;
        end
`else
        if (push_state && nmi_edge) begin
            nmi_pend_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= S_RST_LO;
            cnt_q        <= '0;
            tick_q       <= 1'b0;
            pc_lo_q      <= 8'h00;
            pc_q         <= 16'h0000;
            sp_q         <= 8'h00;
            stat_q       <= 8'h00;
            vec_q        <= 16'h0000;
            nmi_prev_q   <= 1'b0;
            nmi_pend_q   <= 1'b0;
            done_q       <= 1'b0;
            pc_out_q     <= 16'h0000;
            sp_out_q     <= 8'hFD;
            status_out_q <= 8'h24;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tick_q       <= tick_d;
            pc_lo_q      <= pc_lo_d;
            pc_q         <= pc_d;
            sp_q         <= sp_d;
            stat_q       <= stat_d;
            vec_q        <= vec_d;
            nmi_prev_q   <= nmi_prev_d;
            nmi_pend_q   <= nmi_pend_d;
            done_q       <= done_d;
            pc_out_q     <= pc_out_d;
            sp_out_q     <= sp_out_d;
            status_out_q <= status_out_d;
        end
    end

    // Bus drive is a pure function of state, so the address stays stable
    // across any number of stalled read ticks.
    always_comb begin
        address_o       = 16'h0000;
        address_valid_o = 1'b1;
        data_valid_o    = 1'b0;
        data_o          = 8'h00;
        busy_o          = 1'b1;
        case (state_q)
            S_RST_LO: address_o = RESET_VECTOR;
            S_RST_HI: address_o = RESET_VECTOR + 16'd1;
            S_IDLE: begin
                address_valid_o = 1'b0;
                busy_o          = 1'b0;
            end
            S_PUSH_H: begin
                address_o    = {STACK_PAGE, sp_q};
                data_valid_o = 1'b1;
                data_o       = pc_q[15:8];
            end
            S_PUSH_L: begin
                address_o    = {STACK_PAGE, sp_q};
                data_valid_o = 1'b1;
                data_o       = pc_q[7:0];
            end
            S_PUSH_P: begin
                address_o    = {STACK_PAGE, sp_q};
                data_valid_o = 1'b1;
                data_o       = {stat_q[7:6], 1'b1, 1'b0, stat_q[3:0]};
            end
            S_VEC_LO: address_o = vec_q;
            S_VEC_HI: address_o = vec_q + 16'd1;
            default:  address_o = 16'h0000;
        endcase
    end

    assign done_o        = done_q;
    assign pc_o          = pc_out_q;
    assign sp_o          = sp_out_q;
    assign status_o      = status_out_q;
    assign clock_ready_o = tick_q;

endmodule

// File: tb/tb_cpu_interrupt_sequencer.sv
module tb_cpu_interrupt_sequencer;

    localparam int          DIV     = 3;
    localparam logic [15:0] NMI_VEC = 16'hFFFA;
    localparam logic [15:0] IRQ_VEC = 16'hFFFE;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [7:0]  data_i;
    logic        data_valid_i = 1'b0;
    logic        nmi_i = 1'b0;
    logic        irq_i = 1'b0;
    logic        boundary_i = 1'b0;
    logic [15:0] pc_i = 16'h0000;
    logic [7:0]  sp_i = 8'h00;
    logic [7:0]  status_i = 8'h00;
    logic [7:0]  data_o;
    logic [15:0] address_o;
    logic        address_valid_o;
    logic        data_valid_o;
    logic        busy_o;
    logic        done_o;
    logic [15:0] pc_o;
    logic [7:0]  sp_o;
    logic [7:0]  status_o;
    logic        clock_ready_o;

    always #5 clk = ~clk;

    cpu_interrupt_sequencer #(.CLOCK_DIVIDER(DIV)) dut (
        .clock_i(clk), .reset_i(reset_i), .data_i(data_i),
        .data_valid_i(data_valid_i), .nmi_i(nmi_i), .irq_i(irq_i),
        .boundary_i(boundary_i), .pc_i(pc_i), .sp_i(sp_i),
        .status_i(status_i), .data_o(data_o), .address_o(address_o),
        .address_valid_o(address_valid_o), .data_valid_o(data_valid_o),
        .busy_o(busy_o), .done_o(done_o), .pc_o(pc_o), .sp_o(sp_o),
        .status_o(status_o), .clock_ready_o(clock_ready_o)
    );

    // Memory model: reads return whatever lives at the presented address.
    logic [7:0] mem [0:65535];
    assign data_i = mem[address_o];

    // 0: data_valid_i low, 1: high, 2: random every clock
    int dv_mode = 1;
    always @(posedge clk) begin
        #2;
        if (dv_mode == 2) data_valid_i = ($urandom_range(0, 1) == 1);
        else              data_valid_i = (dv_mode == 1);
    end

    // Bus monitor: completed cycles as {write, address, data}.
    logic [24:0] bus_log[$];
    logic [24:0] exp_log[$];
    logic [15:0] stall_log[$];
    logic [31:0] done_log[$];
    int          tick_cnt = 0;
    int          done_tick = 0;

    always @(negedge clk) begin
        if (reset_i) begin
            tick_cnt <= 0;
        end else begin
            if (clock_ready_o) begin
                tick_cnt <= tick_cnt + 1;
                if (address_valid_o) begin
                    if (data_valid_o)      bus_log.push_back({1'b1, address_o, data_o});
                    else if (data_valid_i) bus_log.push_back({1'b0, address_o, data_i});
                    else                   stall_log.push_back(address_o);
                end
            end
            if (done_o) begin
                done_log.push_back({pc_o, sp_o, status_o});
                done_tick <= tick_cnt;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        bus_log.delete();
        stall_log.delete();
        done_log.delete();
        exp_log.delete();
    endtask

    task automatic pulse_boundary();
        step();
        boundary_i = 1'b1;
        step();
        boundary_i = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (done_log.size() > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_addr(input logic [15:0] a, input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            #1;
            if (address_valid_o && data_valid_o && address_o == a) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_entry(input logic [15:0] pc, input logic [7:0] sp, input logic [7:0] p);
        pc_i = pc;
        sp_i = sp;
        status_i = p;
        clear_logs();
        pulse_boundary();
    endtask

    // Reference for an interrupt entry: three stack pushes going down from
    // SP, then the two vector bytes. Returns {new PC, new SP, new P}.
    function automatic logic [31:0] model_entry(input logic [15:0] vec, input logic [15:0] pc,
                                                input logic [7:0] sp, input logic [7:0] p);
        logic [7:0]  s;
        logic [15:0] v1;
        s = sp;
        exp_log.push_back({1'b1, 8'h01, s, pc[15:8]});
        s = s - 8'd1;
        exp_log.push_back({1'b1, 8'h01, s, pc[7:0]});
        s = s - 8'd1;
        exp_log.push_back({1'b1, 8'h01, s, (p & 8'hEF) | 8'h20});
        s = s - 8'd1;
        v1 = vec + 16'd1;
        exp_log.push_back({1'b0, vec, mem[vec]});
        exp_log.push_back({1'b0, v1, mem[v1]});
        return {mem[v1], mem[vec], s, p | 8'h04};
    endfunction

    function automatic int log_diff();
        if (bus_log.size() != exp_log.size()) return -2;
        foreach (exp_log[i]) if (bus_log[i] !== exp_log[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] first_done();
        return (done_log.size() > 0) ? done_log[0] : 32'hxxxxxxxx;
    endfunction

    task automatic test_reset();
        int t1, t2;
        bit ok;
        int d;
        mem[16'hFFFC] = 8'h34;
        mem[16'hFFFD] = 8'h12;
        dv_mode = 1;
        reset_i = 1'b1;
        step();
        step();
        @(negedge clk);
        checks++;
        if ({busy_o, address_valid_o, data_valid_o, done_o, clock_ready_o} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 11000", {busy_o, address_valid_o, data_valid_o, done_o, clock_ready_o});
        end
        checks++;
        if (address_o !== 16'hFFFC || data_o !== 8'h00) begin
            errors++;
            $display("FAIL reset_bus got addr %h data %h want FFFC 00", address_o, data_o);
        end
        checks++;
        if ({pc_o, sp_o, status_o} !== 32'h0000FD24) begin
            errors++;
            $display("FAIL reset_outs got %h want 0000FD24", {pc_o, sp_o, status_o});
        end
        step();
        clear_logs();
        reset_i = 1'b0;
        t1 = -1;
        t2 = -1;
        for (int k = 0; k <= 2 * DIV; k++) begin
            @(negedge clk);
            if (clock_ready_o) begin
                if (t1 < 0) t1 = k;
                else if (t2 < 0) t2 = k;
            end
        end
        checks++;
        if (t1 != DIV) begin
            errors++;
            $display("FAIL first_tick got clock %0d want %0d", t1, DIV);
        end
        checks++;
        if (t2 - t1 != DIV) begin
            errors++;
            $display("FAIL tick_period got %0d want %0d", t2 - t1, DIV);
        end
        wait_done(100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL reset_done got timeout want done pulse");
        end
        checks++;
        if (first_done()[31:16] !== 16'h1234 || done_tick != 2) begin
            errors++;
            $display("FAIL reset_pc got %h at tick %0d want 1234 at tick 2", first_done()[31:16], done_tick);
        end
        exp_log.push_back({1'b0, 16'hFFFC, 8'h34});
        exp_log.push_back({1'b0, 16'hFFFD, 8'h12});
        d = log_diff();
        checks++;
        if (d != -1) begin
            errors++;
            $display("FAIL reset_bus_seq got diff %0d want -1", d);
        end
        checks++;
        if (busy_o !== 1'b0 || address_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy %b avalid %b want 0 0", busy_o, address_valid_o);
        end
    endtask

    task automatic test_stall();
        bit ok;
        int bad;
        dv_mode = 0;
        reset_i = 1'b1;
        repeat (3) step();
        clear_logs();
        reset_i = 1'b0;
        for (int i = 0; i < 100 && tick_cnt < 3; i++) begin
            @(negedge clk);
            #1;
        end
        dv_mode = 1;
        wait_done(100, ok);
        checks++;
        if (!ok || done_tick != 5) begin
            errors++;
            $display("FAIL stall_latency got ok %0d tick %0d want 1 5", ok, done_tick);
        end
        bad = 0;
        foreach (stall_log[i]) if (stall_log[i] !== 16'hFFFC) bad++;
        checks++;
        if (stall_log.size() != 3 || bad != 0) begin
            errors++;
            $display("FAIL stall_addr got %0d stalls %0d off-address want 3 0", stall_log.size(), bad);
        end
        checks++;
        if (first_done()[31:16] !== 16'h1234) begin
            errors++;
            $display("FAIL stall_pc got %h want 1234", first_done()[31:16]);
        end
    endtask

    task automatic test_irq_entry();
        bit ok;
        int d;
        logic [31:0] res;
        mem[16'hFFFE] = 8'h00;
        mem[16'hFFFF] = 8'h80;
        irq_i = 1'b1;
        start_entry(16'hC005, 8'hFF, 8'h20);
        res = model_entry(IRQ_VEC, 16'hC005, 8'hFF, 8'h20);
        wait_done(300, ok);
        irq_i = 1'b0;
        d = log_diff();
        checks++;
        if (!ok || d != -1) begin
            errors++;
            $display("FAIL irq_bus got ok %0d diff %0d want 1 -1", ok, d);
        end
        checks++;
        if (first_done() !== 32'h8000FC24 || res !== 32'h8000FC24) begin
            errors++;
            $display("FAIL irq_result got %h model %h want 8000FC24", first_done(), res);
        end
    endtask

    task automatic test_nmi_priority();
        bit ok;
        int d;
        logic [31:0] res;
        mem[16'hFFFA] = 8'h78;
        mem[16'hFFFB] = 8'h56;
        nmi_i = 1'b1;
        irq_i = 1'b1;
        step();
        start_entry(16'hABCD, 8'h01, 8'h20);
        res = model_entry(NMI_VEC, 16'hABCD, 8'h01, 8'h20);
        wait_done(300, ok);
        d = log_diff();
        checks++;
        if (!ok || d != -1) begin
            errors++;
            $display("FAIL nmi_bus got ok %0d diff %0d want 1 -1", ok, d);
        end
        checks++;
        if (first_done() !== res || first_done()[15:8] !== 8'hFE) begin
            errors++;
            $display("FAIL nmi_result got %h want %h", first_done(), res);
        end
        // IRQ is still asserted and unmasked: it follows at the next boundary.
        start_entry(16'h5678, 8'h40, 8'h00);
        res = model_entry(IRQ_VEC, 16'h5678, 8'h40, 8'h00);
        wait_done(300, ok);
        irq_i = 1'b0;
        nmi_i = 1'b0;
        d = log_diff();
        checks++;
        if (!ok || d != -1 || first_done() !== res) begin
            errors++;
            $display("FAIL irq_after_nmi got ok %0d diff %0d result %h want 1 -1 %h", ok, d, first_done(), res);
        end
    endtask

    task automatic test_irq_masked();
        bit seen;
        irq_i = 1'b1;
        start_entry(16'h1000, 8'h20, 8'h24);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (busy_o) seen = 1'b1;
        end
        #1;
        irq_i = 1'b0;
        checks++;
        if (seen || bus_log.size() != 0 || done_log.size() != 0) begin
            errors++;
            $display("FAIL irq_masked got busy %b cycles %0d want 0 0", seen, bus_log.size());
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int d;
        irq_i = 1'b1;
        start_entry(16'h1111, 8'h80, 8'h00);
        wait_addr(16'h017F, 300, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_reach got timeout want PUSH_L at 017F");
        end
        reset_i = 1'b1;
        irq_i = 1'b0;
        @(negedge clk);
        checks++;
        if (address_o !== 16'hFFFC || busy_o !== 1'b1 || data_valid_o !== 1'b0 || done_log.size() != 0) begin
            errors++;
            $display("FAIL rstmid_abort got addr %h busy %b wr %b dones %0d want FFFC 1 0 0",
                     address_o, busy_o, data_valid_o, done_log.size());
        end
        step();
        step();
        clear_logs();
        reset_i = 1'b0;
        wait_done(200, ok);
        repeat (10) @(negedge clk);
        #1;
        exp_log.push_back({1'b0, 16'hFFFC, 8'h34});
        exp_log.push_back({1'b0, 16'hFFFD, 8'h12});
        d = log_diff();
        checks++;
        if (done_log.size() != 1 || first_done()[31:16] !== 16'h1234 || d != -1) begin
            errors++;
            $display("FAIL rstmid_restart got dones %0d pc %h diff %0d want 1 1234 -1",
                     done_log.size(), first_done()[31:16], d);
        end
    endtask

    task automatic test_nmi_during_irq();
        bit ok;
        int d;
        logic [31:0] res;
        mem[16'hFFFA] = 8'h11;
        mem[16'hFFFB] = 8'h22;
        mem[16'hFFFE] = 8'h33;
        mem[16'hFFFF] = 8'h44;
        nmi_i = 1'b0;
        irq_i = 1'b1;
        start_entry(16'h2222, 8'h90, 8'h00);
        wait_addr(16'h018F, 300, ok);
        nmi_i = 1'b1;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hijack_reach got timeout want PUSH_L at 018F");
        end
`ifdef CPU_INTERRUPT_SEQUENCER_NMI_HIJACK_EN
        res = model_entry(NMI_VEC, 16'h2222, 8'h90, 8'h00);
`else
        res = model_entry(IRQ_VEC, 16'h2222, 8'h90, 8'h00);
`endif
        wait_done(300, ok);
        irq_i = 1'b0;
        d = log_diff();
        checks++;
        if (!ok || d != -1 || first_done() !== res) begin
            errors++;
            $display("FAIL hijack_first got ok %0d diff %0d result %h want 1 -1 %h", ok, d, first_done(), res);
        end
`ifdef CPU_INTERRUPT_SEQUENCER_NMI_HIJACK_EN
        start_entry(16'h3333, 8'h50, 8'h00);
        repeat (20) @(negedge clk);
        #1;
        checks++;
        if (bus_log.size() != 0 || done_log.size() != 0) begin
            errors++;
            $display("FAIL hijack_no_second got cycles %0d dones %0d want 0 0", bus_log.size(), done_log.size());
        end
`else
        start_entry(16'h3333, 8'h50, 8'h00);
        res = model_entry(NMI_VEC, 16'h3333, 8'h50, 8'h00);
        wait_done(300, ok);
        d = log_diff();
        checks++;
        if (!ok || d != -1 || first_done() !== res) begin
            errors++;
            $display("FAIL pending_nmi got ok %0d diff %0d result %h want 1 -1 %h", ok, d, first_done(), res);
        end
`endif
        nmi_i = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        int kind;
        int d;
        logic [15:0] pc;
        logic [15:0] vec;
        logic [7:0]  sp;
        logic [7:0]  p;
        logic [31:0] res;
        dv_mode = 2;
        for (int it = 0; it < 12; it++) begin
            for (int a = 0; a < 6; a++) mem[16'hFFFA + 16'(a)] = 8'($urandom);
            kind = $urandom_range(0, 2);
            pc = 16'($urandom);
            sp = 8'($urandom);
            p = 8'($urandom);
            nmi_i = 1'b0;
            irq_i = 1'b0;
            step();
            step();
            vec = IRQ_VEC;
            if (kind == 0) begin
                nmi_i = 1'b1;
                irq_i = ($urandom_range(0, 1) == 1);
                vec = NMI_VEC;
            end else begin
                irq_i = 1'b1;
                p[2] = (kind == 2);
            end
            start_entry(pc, sp, p);
            if (kind == 2) begin
                repeat (12) @(negedge clk);
                #1;
                checks++;
                if (bus_log.size() != 0 || done_log.size() != 0 || busy_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_masked it %0d got cycles %0d busy %b want 0 0", it, bus_log.size(), busy_o);
                end
            end else begin
                res = model_entry(vec, pc, sp, p);
                wait_done(3000, ok);
                d = log_diff();
                checks++;
                if (!ok || d != -1) begin
                    errors++;
                    $display("FAIL rand_bus it %0d got ok %0d diff %0d want 1 -1", it, ok, d);
                end
                checks++;
                if (first_done() !== res) begin
                    errors++;
                    $display("FAIL rand_result it %0d got %h want %h", it, first_done(), res);
                end
            end
            irq_i = 1'b0;
        end
        nmi_i = 1'b0;
        dv_mode = 1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        test_reset();
        test_stall();
        test_irq_entry();
        test_nmi_priority();
        test_irq_masked();
        test_reset_mid();
        test_nmi_during_irq();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog got no finish want finish before 90000 cycles");
        $fatal(1, "watchdog");
    end

endmodule
